dmem_sized: RTL
===============

DMEM_SIZED -- requirements
Module: dmem_sized

Interface
REQ-001 SHALL have parameter n, default 32, data and address width in bits; legal values 32 or 64.
REQ-002 SHALL have parameter r, default 7, giving depth 2^r words of n bits.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit, request present.
REQ-006 SHALL have port req_ready, output, 1 bit, block can accept a request.
REQ-007 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word (32b), 11 dword (64b, legal only when n=64).
REQ-009 SHALL have port req_unsigned, input, 1 bit: 1 = zero-extend loads, 0 = sign-extend loads.
REQ-010 SHALL have port req_addr, input, n bits, byte address.
REQ-011 SHALL have port req_wdata, input, n bits, store data in LSBs.
REQ-012 SHALL have port clear_req, input, 1 bit, request a memory wipe.
REQ-013 SHALL have port rsp_valid, output, 1 bit, response strobe.
REQ-014 SHALL have port rsp_rdata, output, n bits, load result.
REQ-015 SHALL have port rsp_err, output, 1 bit, request rejected as misaligned or illegal size.
REQ-016 SHALL have port clearing, output, 1 bit, high while a wipe is in progress.

Function
REQ-017 SHALL use little-endian byte lanes.
- Word index = req_addr[r+k-1:k], k = log2(n/8).
- Byte offset = req_addr[k-1:0].
- Address bits above r+k-1 are ignored.
REQ-018 SHALL implement a two-state FSM: CLEAR and IDLE. req_ready = 1 only in IDLE.
REQ-019 In CLEAR, SHALL write zero to the word at an r-bit counter each cycle and increment the counter. After word 2^r-1 it SHALL go to IDLE, so the wipe takes exactly 2^r cycles. clearing = (state == CLEAR).
REQ-020 A request SHALL be accepted on an edge where req_valid && req_ready.
REQ-021 Every accepted request SHALL produce exactly one rsp_valid pulse on the following cycle, with no back-pressure.
REQ-022 On a legal store, SHALL write only the addressed lanes with the low bytes of req_wdata, at the accepting edge. The response carries rsp_rdata = 0 and rsp_err = 0.
REQ-023 On a legal load, SHALL read the addressed lanes, shift them to the LSBs, and sign- or zero-extend to n bits. Latency is 1 cycle (registered).
REQ-024 A request SHALL be flagged rsp_err = 1 with rsp_rdata = 0, and memory left untouched, in either case:
- the byte offset is not a multiple of the access size;
- req_size = 11 with n = 32.
REQ-025 A load accepted the cycle after a store to the same word SHALL return the newly written data.
REQ-026 Back-to-back accepted requests SHALL sustain one per cycle.
REQ-027 clear_req sampled high in IDLE SHALL move the FSM to CLEAR on the next cycle with the counter at 0.
REQ-028 If a request is accepted on the same edge as clear_req, that request SHALL complete normally and its response SHALL still be issued.
REQ-029 clear_req SHALL be ignored while in CLEAR.
REQ-030 rsp_valid, rsp_rdata and rsp_err SHALL be zero whenever rsp_valid is 0.

Reset
REQ-031 On reset assertion, the block SHALL immediately (asynchronously) drive:
- state = CLEAR, counter = 0;
- rsp_valid = 0, rsp_rdata = 0, rsp_err = 0;
- clearing = 1, req_ready = 0.
REQ-032 Reset mid-operation SHALL discard any pending response and restart the full 2^r-cycle wipe after deassertion.
REQ-033 Memory contents SHALL NOT be reset asynchronously; they are zeroed only by the CLEAR sweep.

Verification (n=32, r=7)
REQ-034 Release reset: req_ready = 0 and clearing = 1 for exactly 128 cycles, then req_ready = 1. Then load word 0x54 -> rsp_rdata = 0x00000000.
REQ-035 Store word 0xDEADBEEF at 0x54, load word at 0x54 next cycle -> 0xDEADBEEF. Then:
- signed byte load at 0x55 -> 0xFFFFFFBE;
- unsigned byte load at 0x55 -> 0x000000BE.
REQ-036 Store half 0x1234 at 0x56, then load word 0x54 -> 0x1234BEEF. Signed half load at 0x56 -> 0x00001234.
REQ-037 Store half at 0x55, and separately issue a dword request -> rsp_err = 1 for each; load word 0x54 still returns 0x1234BEEF.
REQ-038 After writing word 0x2A to word 0x2A:
- assert clear_req together with an accepted load of 0x2A -> load returns 0x0000002A, then clearing = 1 for 128 cycles, then load -> 0;
- assert reset at cycle 50 of the sweep -> sweep restarts, and req_ready stays low for 128 cycles after release.

Source files
------------

// File: rtl/dmem_sized.sv
// Byte-addressable data memory with sized, sign/zero-extending loads and a
// power-up / on-demand wipe sweep. One request per cycle, one-cycle response.
module dmem_sized #(
   parameter int n = 32,
   parameter int r = 7
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_we,
   input  logic [1:0]   req_size,
   input  logic         req_unsigned,
   input  logic [n-1:0] req_addr,
   input  logic [n-1:0] req_wdata,
   input  logic         clear_req,
   output logic         rsp_valid,
   output logic [n-1:0] rsp_rdata,
   output logic         rsp_err,
   output logic         clearing
);

   // Handshake: a request is taken on a rising edge where req_valid && req_ready;
   // its response appears as a single rsp_valid cycle right after, never stalled.

   localparam int k  = $clog2(n / 8);
   localparam int nb = n / 8;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   state_t         state, state_nx;
   logic [r-1:0]   cnt, cnt_nx;
   logic [n-1:0]   mem [2**r];

   logic [r-1:0]   idx;
   logic [k-1:0]   off;
   logic           accept;
   logic           misalign;
   logic           bad_size;
   logic           err;
   logic [n-1:0]   word;
   logic [n-1:0]   sh;
   logic [n-1:0]   mask;
   logic           sign;
   logic [n-1:0]   load_val;
   logic [n-1:0]   wsh;
   logic [3:0]     span;
   logic [nb-1:0]  be;
   logic           unused_addr;

   // Address bits above the memory span are deliberately don't-care.
   assign unused_addr = ^req_addr[n-1:r+k];

   assign idx       = req_addr[r+k-1:k];
   assign off       = req_addr[k-1:0];
   assign req_ready = (state == IDLE);
   assign clearing  = (state == CLEAR);
   assign accept    = req_valid && req_ready;
   assign err       = misalign || bad_size;

   always_comb begin
      misalign = 1'b0;
      bad_size = 1'b0;
      case (req_size)
         2'b00:   misalign = 1'b0;
         2'b01:   misalign = off[0];
         2'b10:   misalign = |off[1:0];
         default: begin
            misalign = |off;
            bad_size = (n == 32);
         end
      endcase
   end

   // Load path: shift addressed lanes down, then mask and extend by size.
   assign word = mem[idx];
   assign sh   = word >> {off, 3'b000};

   always_comb begin
      mask = '1;
      sign = 1'b0;
      case (req_size)
         2'b00: begin
            mask = n'(8'hFF);
            sign = sh[7];
         end
         2'b01: begin
            mask = n'(16'hFFFF);
            sign = sh[15];
         end
         2'b10: begin
            mask = n'(32'hFFFF_FFFF);
            sign = sh[31];
         end
         default: begin
            mask = '1;
            sign = 1'b0;
         end
      endcase
      load_val = sh & mask;
      if (!req_unsigned && sign) load_val = load_val | ~mask;
   end

   // Store path: byte enables cover [off, off+span) in little-endian lanes.
   assign wsh  = req_wdata << {off, 3'b000};
   assign span = 4'd1 << req_size;

   always_comb begin
      be = '0;
      for (int b = 0; b < nb; b++) begin
         be[b] = (b >= int'(off)) && (b < int'(off) + int'(span));
      end
   end

   // Memory array has no reset; only the sweep zeroes it.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[cnt] <= '0;
      end else if (accept && req_we && !err) begin
         for (int b = 0; b < nb; b++) begin
            if (be[b]) mem[idx][b*8 +: 8] <= wsh[b*8 +: 8];
         end
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         CLEAR: begin
            cnt_nx = cnt + r'(1);
            if (cnt == '1) state_nx = IDLE;
         end
         IDLE: begin
            if (clear_req) begin
               state_nx = CLEAR;
               cnt_nx   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= CLEAR;
         cnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         rsp_valid <= accept;
         rsp_err   <= accept && err;
         rsp_rdata <= (accept && !req_we && !err) ? load_val : '0;
      end
   end

endmodule
